irq_trap_ctrl: RTL and testbench

Interrupt controller and trap sequencer in front of the CSR register file. It synchronises the external interrupt and samples the timer interrupt, then masks them with mstatus.MIE and the mie enable bits. It prioritises the surviving requests and runs the trap-entry / mret-return sequence. It drives the CSR file's interrupt strobe, mcause value, pipeline flush and return strobe, and blocks nested traps until mret.

---
 rtl/irq_trap_ctrl_if.sv | 37 +++
 rtl/irq_trap_ctrl.sv | 145 ++++++++++++++
 tb/tb_irq_trap_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/irq_trap_ctrl_if.sv
// irq_trap_ctrl_if
// CSR/pipeline-facing bundle of the interrupt/trap controller.
//   mstatus_mie_i  global interrupt enable (mstatus[3])
//   mie_meie_i     external interrupt enable (mie[11])
//   mie_mtie_i     timer interrupt enable (mie[7])
//   stall_i        pipeline stall, holds off trap entry
//   mret_i         mret decoded in execute, one-cycle valid
//   irq_take_o     one-cycle pulse: capture PC into mepc, redirect to mtvec
//   flush_o        flush fetch/decode
//   mret_take_o    one-cycle pulse: redirect to mepc
//   mcause_o       cause of the last taken trap
//   mip_o          pending view (bit 11 MEIP, bit 7 MTIP)
//   in_handler_o   trap handler active
// Modports: master = CSR file / pipeline side, slave = the controller.
interface irq_trap_ctrl_if;
  logic        mstatus_mie_i;
  logic        mie_meie_i;
  logic        mie_mtie_i;
  logic        stall_i;
  logic        mret_i;
  logic        irq_take_o;
  logic        flush_o;
  logic        mret_take_o;
  logic [31:0] mcause_o;
  logic [31:0] mip_o;
  logic        in_handler_o;

  modport master (
    output mstatus_mie_i, mie_meie_i, mie_mtie_i, stall_i, mret_i,
    input  irq_take_o, flush_o, mret_take_o, mcause_o, mip_o, in_handler_o
  );

  modport slave (
    input  mstatus_mie_i, mie_meie_i, mie_mtie_i, stall_i, mret_i,
    output irq_take_o, flush_o, mret_take_o, mcause_o, mip_o, in_handler_o
  );
endinterface

// File: rtl/irq_trap_ctrl.sv
// irq_trap_ctrl
// Interrupt controller and trap sequencer sitting in front of the CSR file.
// Synchronises the external interrupt, samples the timer level, masks both
// with mstatus.MIE / mie, prioritises external over timer and runs the
// trap-entry / mret-return sequence. Nested traps are blocked until mret.
//
// Parameters:
//   SYNC_STAGES  flops on ext_irq_i before edge detection (must be >= 2)
// Ports:
//   clk          core clock, rising edge
//   reset        asynchronous, active-low reset
//   ext_irq_i    asynchronous external interrupt line (rising edge = request)
//   timer_irq_i  synchronous timer interrupt level
//   bus          irq_trap_ctrl_if.slave (enables, stall, mret, strobes, CSRs)
// Configuration macro:
//   TIMER_IRQ_EN  defined: timer source active; undefined: timer tied off,
//                 mip_o[7]=0 and cause 7 is never produced.
module irq_trap_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ext_irq_i,
  input  logic             timer_irq_i,
  irq_trap_ctrl_if.slave   bus
);

  localparam logic [31:0] CAUSE_EXT = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TMR = 32'h8000_0007;

  typedef enum logic [1:0] {IDLE, ENTER, HANDLER, RETURN} state_t;

  state_t                 state_reg;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_prev_reg;
  // Shift register of ones that fills after reset release; edge detection is
  // armed only once both the synchroniser output and its delayed copy hold
  // real samples, so a line already high at reset release is not an edge.
  logic [SYNC_STAGES:0]   prime_reg;
  logic                   ext_pend_reg;
  logic                   ext_pend_next;
  logic                   irq_take_reg;
  logic                   mret_take_reg;
  logic                   flush_reg;
  logic                   in_handler_reg;
  logic [31:0]            mcause_reg;

  logic ext_rise;
  logic tmr_pend;
  logic elig_ext;
  logic elig_tmr;
  logic take_req;

`ifdef TIMER_IRQ_EN
  assign tmr_pend = timer_irq_i;
  assign elig_tmr = tmr_pend & bus.mie_mtie_i & bus.mstatus_mie_i;
`else
  logic unused_timer;
  assign unused_timer = timer_irq_i ^ bus.mie_mtie_i;
  assign tmr_pend = 1'b0;
  assign elig_tmr = 1'b0;
`endif

  assign ext_rise = prime_reg[SYNC_STAGES] & sync_reg[SYNC_STAGES-1] & ~sync_prev_reg;
  assign elig_ext = ext_pend_reg & bus.mie_meie_i & bus.mstatus_mie_i;
  assign take_req = (state_reg == IDLE) & (elig_ext | elig_tmr) & ~bus.stall_i;

  // Clear on external trap entry, but a simultaneous new edge wins.
  always_comb begin
    ext_pend_next = ext_pend_reg;
    if (take_req && elig_ext) begin
      ext_pend_next = 1'b0;
    end
    if (ext_rise) begin
      ext_pend_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg      <= '0;
      sync_prev_reg <= 1'b0;
      prime_reg     <= '0;
      ext_pend_reg  <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[SYNC_STAGES-2:0], ext_irq_i};
      sync_prev_reg <= sync_reg[SYNC_STAGES-1];
      prime_reg     <= {prime_reg[SYNC_STAGES-1:0], 1'b1};
      ext_pend_reg  <= ext_pend_next;
    end
  end

  // Trap sequencer; all outputs are registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      irq_take_reg   <= 1'b0;
      mret_take_reg  <= 1'b0;
      flush_reg      <= 1'b0;
      in_handler_reg <= 1'b0;
      mcause_reg     <= '0;
    end else begin
      irq_take_reg  <= 1'b0;
      mret_take_reg <= 1'b0;
      flush_reg     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (take_req) begin
            state_reg    <= ENTER;
            irq_take_reg <= 1'b1;
            flush_reg    <= 1'b1;
            mcause_reg   <= elig_ext ? CAUSE_EXT : CAUSE_TMR;
          end
        end
        ENTER: begin
          state_reg      <= HANDLER;
          in_handler_reg <= 1'b1;
        end
        HANDLER: begin
          if (bus.mret_i) begin
            state_reg     <= RETURN;
            mret_take_reg <= 1'b1;
            flush_reg     <= 1'b1;
          end
        end
        RETURN: begin
          state_reg      <= IDLE;
          in_handler_reg <= 1'b0;
        end
        default: begin
          state_reg      <= IDLE;
          in_handler_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq_take_o   = irq_take_reg;
  assign bus.mret_take_o  = mret_take_reg;
  assign bus.flush_o      = flush_reg;
  assign bus.in_handler_o = in_handler_reg;
  assign bus.mcause_o     = mcause_reg;
  assign bus.mip_o        = {20'b0, ext_pend_reg, 3'b0, tmr_pend, 7'b0};

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// tb_irq_trap_ctrl
// Scoreboard bench for irq_trap_ctrl: stimulus pushes expected strobes
// (kind, cycle, cause) into a queue; a monitor on the falling edge pops and
// compares whenever irq_take_o or mret_take_o is seen.
module tb_irq_trap_ctrl;

  typedef struct {
    bit          is_mret;
    int          cyc;
    logic [31:0] cause;
  } exp_t;

  localparam logic [31:0] CAUSE_EXT = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TMR = 32'h8000_0007;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ext_irq = 1'b0;
  logic timer_irq = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  irq_trap_ctrl_if bus ();

  irq_trap_ctrl #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .ext_irq_i   (ext_irq),
    .timer_irq_i (timer_irq),
    .bus         (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_take(input int c, input logic [31:0] cause);
    exp_t e;
    e.is_mret = 1'b0;
    e.cyc     = c;
    e.cause   = cause;
    exp_q.push_back(e);
  endtask

  task automatic push_mret(input int c);
    exp_t e;
    e.is_mret = 1'b1;
    e.cyc     = c;
    e.cause   = '0;
    exp_q.push_back(e);
  endtask

  task automatic do_mret();
    bus.mret_i = 1'b1;
    push_mret(cyc + 1);
    tick(1);
    bus.mret_i = 1'b0;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (reset && (bus.irq_take_o || bus.mret_take_o)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got irq_take=%b mret_take=%b expected none (cycle %0d)",
                 bus.irq_take_o, bus.mret_take_o, cyc);
      end else begin
        e = exp_q.pop_front();
        $display("txn cycle=%0d irq_take=%b mret_take=%b mcause=%h", cyc,
                 bus.irq_take_o, bus.mret_take_o, bus.mcause_o);
        chk("strobe_kind", {31'b0, bus.mret_take_o}, {31'b0, e.is_mret});
        chk("strobe_both", {31'b0, bus.irq_take_o & bus.mret_take_o}, 32'd0);
        chk("strobe_cycle", cyc, e.cyc);
        chk("strobe_flush", {31'b0, bus.flush_o}, 32'd1);
        if (!e.is_mret) chk("mcause", bus.mcause_o, e.cause);
      end
    end else if (reset && bus.flush_o) begin
      checks++;
      errors++;
      $display("FAIL stray_flush: got flush=1 expected 0 (cycle %0d)", cyc);
    end
  end

  initial begin
    int m;
    bus.mstatus_mie_i = 1'b0;
    bus.mie_meie_i    = 1'b0;
    bus.mie_mtie_i    = 1'b0;
    bus.stall_i       = 1'b0;
    bus.mret_i        = 1'b0;

    // Reset held with ext line high
    ext_irq = 1'b1;
    tick(3);
    chk("rst_irq_take", {31'b0, bus.irq_take_o}, 32'd0);
    chk("rst_flush", {31'b0, bus.flush_o}, 32'd0);
    chk("rst_mret_take", {31'b0, bus.mret_take_o}, 32'd0);
    chk("rst_mcause", bus.mcause_o, 32'd0);
    chk("rst_mip", bus.mip_o, 32'd0);
    chk("rst_in_handler", {31'b0, bus.in_handler_o}, 32'd0);

    // Release with line still high: no edge, no trap even though enabled
    bus.mstatus_mie_i = 1'b1;
    bus.mie_meie_i    = 1'b1;
    bus.mie_mtie_i    = 1'b1;
    tick(1);
    reset = 1'b1;
    tick(8);
    chk("noedge_mip", bus.mip_o, 32'd0);
    chk("noedge_in_handler", {31'b0, bus.in_handler_o}, 32'd0);
    ext_irq = 1'b0;
    tick(4);

    // External edge: pending at +3, take at +4
    ext_irq = 1'b1;
    push_take(cyc + 4, CAUSE_EXT);
    tick(3);
    chk("ext_mip11_set", {31'b0, bus.mip_o[11]}, 32'd1);
    tick(1);
    chk("ext_mip11_clr", {31'b0, bus.mip_o[11]}, 32'd0);
    tick(2);
    chk("ext_in_handler", {31'b0, bus.in_handler_o}, 32'd1);
    ext_irq = 1'b0;
    do_mret();
    tick(4);
    chk("ext_after_ret", {31'b0, bus.in_handler_o}, 32'd0);

    // External and timer pending together, then globally enabled
    bus.mstatus_mie_i = 1'b0;
    ext_irq   = 1'b1;
    timer_irq = 1'b1;
    tick(5);
`ifdef TIMER_IRQ_EN
    chk("both_mip", bus.mip_o, 32'h0000_0880);
`else
    chk("both_mip", bus.mip_o, 32'h0000_0800);
`endif
    bus.mstatus_mie_i = 1'b1;
    push_take(cyc + 1, CAUSE_EXT);
    tick(3);
    ext_irq = 1'b0;
    m = cyc;
`ifdef TIMER_IRQ_EN
    push_take(m + 3, CAUSE_TMR);
`endif
    do_mret();
    tick(4);
`ifdef TIMER_IRQ_EN
    chk("tmr_second_in_handler", {31'b0, bus.in_handler_o}, 32'd1);
    timer_irq = 1'b0;
    do_mret();
`else
    chk("tmr_second_in_handler", {31'b0, bus.in_handler_o}, 32'd0);
    timer_irq = 1'b0;
`endif
    tick(4);

    // Timer masked by mstatus.MIE, then enabled
    bus.mstatus_mie_i = 1'b0;
    timer_irq = 1'b1;
    tick(3);
`ifdef TIMER_IRQ_EN
    chk("tmr_masked_mip7", {31'b0, bus.mip_o[7]}, 32'd1);
    bus.mstatus_mie_i = 1'b1;
    push_take(cyc + 1, CAUSE_TMR);
    tick(3);
    timer_irq = 1'b0;
    do_mret();
`else
    chk("tmr_masked_mip7", {31'b0, bus.mip_o[7]}, 32'd0);
    bus.mstatus_mie_i = 1'b1;
    tick(3);
    chk("tmr_disabled_no_trap", {31'b0, bus.in_handler_o}, 32'd0);
    timer_irq = 1'b0;
`endif
    tick(4);

    // Stall holds off an eligible external request
    bus.stall_i = 1'b1;
    ext_irq = 1'b1;
    tick(9);
    chk("stall_in_handler", {31'b0, bus.in_handler_o}, 32'd0);
    chk("stall_mip11", {31'b0, bus.mip_o[11]}, 32'd1);
    bus.stall_i = 1'b0;
    push_take(cyc + 1, CAUSE_EXT);
    tick(1);
    ext_irq = 1'b0;
    tick(3);
    chk("stall_handler", {31'b0, bus.in_handler_o}, 32'd1);

    // Reset inside the handler clears everything at once
    reset = 1'b0;
    #1;
    chk("midrst_in_handler", {31'b0, bus.in_handler_o}, 32'd0);
    chk("midrst_mcause", bus.mcause_o, 32'd0);
    chk("midrst_mip", bus.mip_o, 32'd0);
    tick(2);
    reset = 1'b1;
    tick(5);
    bus.mret_i = 1'b1;
    tick(1);
    bus.mret_i = 1'b0;
    tick(4);
    chk("postrst_in_handler", {31'b0, bus.in_handler_o}, 32'd0);
    chk("postrst_mip", bus.mip_o, 32'd0);

    tick(2);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
